alu_rr_sched: RTL and testbench
===============================

// Module: alu_rr_sched
// PURPOSE
//  Shares one registered 8-bit ALU (ctl 000 add, 001 sub, 010 mul, 011 div, 1xx add) among NREQ requesters.
//  Uses round-robin arbitration and valid/ready on both the request and response sides.
//  Sequences each operation: accept, issue, capture the registered ALU result, return it to the owning requester.
//  Sits between client blocks and the ALU instance. The ALU shares clk/rst_n with this block.
// PARAMETERS
//  NREQ            4   number of requesters (2..8)
//  DIV_ZERO_CHECK  1   1: div with b==0 is answered locally with an error and never issued to the ALU
// PORTS
//  clk        in   1        clock, rising edge
//  rst_n      in   1        reset, asynchronous, active-low
//  req_valid  in   NREQ     per-requester operation valid
//  req_ready  out  NREQ     per-requester accept strobe; at most one bit set
//  req_ctl    in   3*NREQ   opcode, requester i at [3i+:3]
//  req_a      in   8*NREQ   operand a, requester i at [8i+:8]
//  req_b      in   8*NREQ   operand b, requester i at [8i+:8]
//  rsp_valid  out  NREQ     response valid, one-hot to the owning requester
//  rsp_ready  in   NREQ     response accept; only the bit matching rsp_valid is examined
//  rsp_data   out  9        result {cout,q}
//  rsp_err    out  1        1 = divide-by-zero, rsp_data = 9'h1FF
//  alu_ctl    out  3        to ALU ctl
//  alu_a      out  8        to ALU a
//  alu_b      out  8        to ALU b
//  alu_q      in   8        from ALU q, registered
//  alu_cout   in   1        from ALU cout, registered
//  busy       out  1        1 whenever FSM != IDLE
// BEHAVIOUR
//  Reset (async): all outputs 0; FSM=IDLE; rr_ptr=NREQ-1, so requester 0 wins first.
//    An in-flight op is dropped: no response is given and the latched operands are cleared.
//  FSM states: IDLE -> ISSUE -> CAPT -> RESP -> IDLE; IDLE -> RESP on divide-by-zero.
//  IDLE
//    - Grant g = first i with req_valid[i] set, searching rr_ptr+1, rr_ptr+2, ... modulo NREQ.
//    - req_ready[g]=1 combinationally in the same cycle. Handshake = valid&ready.
//    - At the edge: owner<=g, rr_ptr<=g.
//    - Normal op: alu_ctl/a/b <= req fields of g, next state ISSUE.
//    - req_ctl==011 && req_b==0 && DIV_ZERO_CHECK: alu_* registers are NOT updated.
//      Set rsp_data<=9'h1FF, rsp_err<=1, next state RESP.
//    - No valid request: stay in IDLE, req_ready=0.
//  ISSUE: ALU inputs stable for one full cycle; the ALU registers its result at the end of this cycle.
//  CAPT: rsp_data<={alu_cout,alu_q}, rsp_err<=0.
//  RESP
//    - rsp_valid[owner]=1. rsp_data and rsp_err are held stable until rsp_ready[owner]=1.
//    - On acceptance, next state IDLE.
//    - No req_ready is asserted outside IDLE.
//  alu_ctl/a/b are registered and hold their values between ops. There are no glitches and no X on the ALU inputs.
//  Latency, handshake in cycle T:
//    - rsp_valid rises at T+3 (normal op) or T+1 (div-by-zero).
//    - Minimum 4 cycles per op, since IDLE must be re-entered.
//  Arithmetic: no modification by this block. Results are the ALU's 9-bit results:
//    - sub wraps mod 512;
//    - mul is truncated to 9 bits;
//    - ctl 1xx is forwarded as-is (ALU adds), rsp_err=0.
//  Requesters must hold req_* stable while req_valid=1 and un-accepted.
//    Deasserting req_valid before the grant is legal; that requester is skipped.
//  rsp_ready on non-owner bits is ignored. A requester may re-request in the cycle after its response is accepted.
// TESTING
//  1. req0 add a=200 b=100 -> req_ready[0] same cycle; rsp_valid=4'b0001 at T+3; rsp_data=9'h12C, rsp_err=0.
//  2. req_valid=4'b1111 held, rsp_ready=1 -> grant order 0,1,2,3,0,1; each op 4 cycles; no requester skipped.
//  3. req2 div a=5 b=0 -> rsp_valid=4'b0100 at T+1, rsp_data=9'h1FF, rsp_err=1; alu_ctl/a/b unchanged from previous op.
//  4. req1 mul 20*20 then sub 5-10 -> rsp_data 9'h190, then 9'h1FB;
//     hold rsp_ready=0 for 5 cycles -> rsp_valid/rsp_data stable, req_ready=0 throughout.
//  5. Assert rst_n=0 during CAPT -> all outputs 0 immediately; after release, no stale response; requester 0 granted first.
//  6. req_valid=4'b1010 with rr_ptr=1 -> grant 3, then 1; ctl=3'b100 a=7 b=8 -> rsp_data=9'h00F, rsp_err=0.

Source files
------------

// File: rtl/alu_rr_sched.sv
// alu_rr_sched
//   Shares one registered 8-bit ALU among NREQ requesters. Requests are
//   granted round-robin. Each accepted operation is issued to the ALU, its
//   registered result is captured, and the result goes back to the owning
//   requester over a valid/ready response channel.
//   A divide by zero (when DIV_ZERO_CHECK=1) is answered locally with
//   rsp_err=1 and data 9'h1FF. It never reaches the ALU.
// Ports
//   clk, rst_n            clock (rising edge) and async active-low reset
//   req_valid/req_ready   per-requester request handshake (ready is one-hot)
//   req_ctl/req_a/req_b   packed per-requester opcode and operands
//   rsp_valid/rsp_ready   per-requester response handshake (valid is one-hot)
//   rsp_data/rsp_err      response payload {cout,q} and divide-by-zero flag
//   alu_ctl/alu_a/alu_b   registered ALU inputs
//   alu_q/alu_cout        registered ALU result
//   busy                  high whenever an operation is in flight
module alu_rr_sched #(
  parameter int NREQ           = 4,
  parameter bit DIV_ZERO_CHECK = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [3*NREQ-1:0]   req_ctl,
  input  logic [8*NREQ-1:0]   req_a,
  input  logic [8*NREQ-1:0]   req_b,
  output logic [NREQ-1:0]     rsp_valid,
  input  logic [NREQ-1:0]     rsp_ready,
  output logic [8:0]          rsp_data,
  output logic                rsp_err,
  output logic [2:0]          alu_ctl,
  output logic [7:0]          alu_a,
  output logic [7:0]          alu_b,
  input  logic [7:0]          alu_q,
  input  logic                alu_cout,
  output logic                busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_CAPT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [PW-1:0]     r_rr_ptr;
  logic [PW-1:0]     r_owner;
  logic [2:0]        r_alu_ctl;
  logic [7:0]        r_alu_a;
  logic [7:0]        r_alu_b;
  logic [8:0]        r_rsp_data;
  logic              r_rsp_err;
  logic [NREQ-1:0]   r_rsp_valid;

  logic              w_found;
  logic [PW-1:0]     w_grant;
  logic [PW-1:0]     w_idx;
  logic [2:0]        w_ctl;
  logic [7:0]        w_a;
  logic [7:0]        w_b;
  logic              w_div0;
  logic [NREQ-1:0]   w_req_ready;

  function automatic logic [NREQ-1:0] f_onehot(input logic [PW-1:0] idx);
    logic [NREQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Round-robin search: first valid requester after the last grant.
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    w_idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_idx = PW'((int'(r_rr_ptr) + k) % NREQ);
      if (!w_found && req_valid[w_idx]) begin
        w_found = 1'b1;
        w_grant = w_idx;
      end else begin
        w_found = w_found;
      end
    end
  end

  // Fields of the granted request and the local divide-by-zero decision.
  always_comb begin
    w_ctl  = req_ctl[3*int'(w_grant) +: 3];
    w_a    = req_a[8*int'(w_grant) +: 8];
    w_b    = req_b[8*int'(w_grant) +: 8];
    w_div0 = DIV_ZERO_CHECK && (w_ctl == 3'b011) && (w_b == 8'd0);
  end

  // Next-state and accept strobe; ready is forced low while reset is applied.
  always_comb begin
    w_next      = r_state;
    w_req_ready = '0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_req_ready = f_onehot(w_grant) & {NREQ{rst_n}};
          w_next      = w_div0 ? S_RESP : S_ISSUE;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_ISSUE: w_next = S_CAPT;
      S_CAPT:  w_next = S_RESP;
      S_RESP: begin
        if (rsp_ready[r_owner]) begin
          w_next = S_IDLE;
        end else begin
          w_next = S_RESP;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State, arbitration pointer, ALU operand and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_rr_ptr    <= PW'(NREQ - 1);
      r_owner     <= '0;
      r_alu_ctl   <= 3'd0;
      r_alu_a     <= 8'd0;
      r_alu_b     <= 8'd0;
      r_rsp_data  <= 9'd0;
      r_rsp_err   <= 1'b0;
      r_rsp_valid <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_owner  <= w_grant;
            r_rr_ptr <= w_grant;
            if (w_div0) begin
              // ALU inputs deliberately keep the previous operation.
              r_rsp_data  <= 9'h1FF;
              r_rsp_err   <= 1'b1;
              r_rsp_valid <= f_onehot(w_grant);
            end else begin
              r_alu_ctl <= w_ctl;
              r_alu_a   <= w_a;
              r_alu_b   <= w_b;
            end
          end
        end
        S_CAPT: begin
          r_rsp_data  <= {alu_cout, alu_q};
          r_rsp_err   <= 1'b0;
          r_rsp_valid <= f_onehot(r_owner);
        end
        S_RESP: begin
          if (rsp_ready[r_owner]) begin
            r_rsp_valid <= '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign req_ready = w_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_err   = r_rsp_err;
  assign alu_ctl   = r_alu_ctl;
  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_alu_rr_sched.sv
module tb_alu_rr_sched;

  localparam int NREQ = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [3:0]      req_valid;
  logic [3:0]      req_ready;
  logic [11:0]     req_ctl;
  logic [31:0]     req_a;
  logic [31:0]     req_b;
  logic [3:0]      rsp_valid;
  logic [3:0]      rsp_ready;
  logic [8:0]      rsp_data;
  logic            rsp_err;
  logic [2:0]      alu_ctl;
  logic [7:0]      alu_a;
  logic [7:0]      alu_b;
  logic [7:0]      alu_q;
  logic            alu_cout;
  logic            busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_rr_sched #(.NREQ(NREQ), .DIV_ZERO_CHECK(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_ctl(req_ctl), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .alu_ctl(alu_ctl), .alu_a(alu_a), .alu_b(alu_b),
    .alu_q(alu_q), .alu_cout(alu_cout), .busy(busy)
  );

  // Stand-in for the external registered ALU.
  logic [8:0] alu_next;
  always_comb begin
    case (alu_ctl)
      3'b001:  alu_next = {1'b0, alu_a} - {1'b0, alu_b};
      3'b010:  alu_next = {1'b0, alu_a} * {1'b0, alu_b};
      3'b011:  alu_next = (alu_b == 8'd0) ? 9'h1FF : {1'b0, alu_a / alu_b};
      default: alu_next = {1'b0, alu_a} + {1'b0, alu_b};
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) {alu_cout, alu_q} <= 9'd0;
    else        {alu_cout, alu_q} <= alu_next;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] oh(input int g);
    logic [3:0] v;
    v    = 4'd0;
    v[g] = 1'b1;
    return v;
  endfunction

  // Reference result {err, data} from the arithmetic rules, in plain integers.
  function automatic logic [9:0] ref_op(input logic [2:0] c, input logic [7:0] a, input logic [7:0] b);
    int ia, ib, r;
    ia = int'(a);
    ib = int'(b);
    if (c == 3'b011 && ib == 0) return {1'b1, 9'h1FF};
    case (c)
      3'b001:  r = (ia - ib + 512) % 512;
      3'b010:  r = (ia * ib) % 512;
      3'b011:  r = ia / ib;
      default: r = ia + ib;
    endcase
    return {1'b0, 9'(r)};
  endfunction

  task automatic set_req(input int i, input logic [2:0] c, input logic [7:0] a, input logic [7:0] b);
    req_valid[i]      = 1'b1;
    req_ctl[3*i +: 3] = c;
    req_a[8*i +: 8]   = a;
    req_b[8*i +: 8]   = b;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    req_valid = 4'd0;
    rsp_ready = 4'd0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Called at a negedge with requests applied: expects grant g, then waits for
  // the response, optionally stalls it, and accepts it.
  task automatic serve(input int g, input logic [8:0] ed, input logic ee, input int stall, input string nm);
    int n;
    int oth;
    oth = (g + 1) % NREQ;
    #1;
    check({nm, ".ready"}, req_ready, oh(g));
    @(negedge clk);
    req_valid[g] = 1'b0;
    n = 1;
    while (rsp_valid == 4'd0 && n < 12) begin
      @(negedge clk);
      n++;
    end
    check({nm, ".latency"}, n, ee ? 1 : 3);
    check({nm, ".rsp_valid"}, rsp_valid, oh(g));
    check({nm, ".rsp_data"}, rsp_data, ed);
    check({nm, ".rsp_err"}, rsp_err, ee);
    for (int s = 0; s < stall; s++) begin
      set_req(oth, 3'b000, 8'd1, 8'd1);
      #1;
      check({nm, ".stall_ready"}, req_ready, 4'd0);
      check({nm, ".stall_valid"}, rsp_valid, oh(g));
      check({nm, ".stall_data"}, rsp_data, ed);
      check({nm, ".stall_err"}, rsp_err, ee);
      @(negedge clk);
    end
    if (stall > 0) req_valid[oth] = 1'b0;
    rsp_ready = oh(g);
    @(negedge clk);
    rsp_ready = 4'd0;
    check({nm, ".rsp_drop"}, rsp_valid, 4'd0);
    check({nm, ".idle"}, busy, 1'b0);
  endtask

  typedef struct {
    int         req;
    logic [2:0] ctl;
    logic [7:0] a;
    logic [7:0] b;
    logic [8:0] exp_data;
    logic       exp_err;
    int         stall;
  } vec_t;

  vec_t vecs[10];

  logic [2:0] last_ctl;
  logic [7:0] last_a, last_b;

  initial begin
    logic [3:0] acc;
    int         m_phase, m_wait, m_ptr, m_owner;
    logic [9:0] m_res;
    int         g_list[$];
    int         c_list[$];

    vecs[0] = '{0, 3'b000, 8'd200, 8'd100, 9'h12C, 1'b0, 0};
    vecs[1] = '{1, 3'b010, 8'd20,  8'd20,  9'h190, 1'b0, 0};
    vecs[2] = '{1, 3'b001, 8'd5,   8'd10,  9'h1FB, 1'b0, 5};
    vecs[3] = '{2, 3'b011, 8'd5,   8'd0,   9'h1FF, 1'b1, 0};
    vecs[4] = '{3, 3'b011, 8'd100, 8'd7,   9'h00E, 1'b0, 0};
    vecs[5] = '{0, 3'b010, 8'd255, 8'd255, 9'h001, 1'b0, 0};
    vecs[6] = '{2, 3'b001, 8'd0,   8'd1,   9'h1FF, 1'b0, 0};
    vecs[7] = '{3, 3'b000, 8'd255, 8'd255, 9'h1FE, 1'b0, 0};
    vecs[8] = '{1, 3'b111, 8'd200, 8'd100, 9'h12C, 1'b0, 2};
    vecs[9] = '{0, 3'b011, 8'd7,   8'd0,   9'h1FF, 1'b1, 0};

    // Reset state with all requests pending.
    rst_n     = 1'b0;
    req_valid = 4'hF;
    rsp_ready = 4'hF;
    req_ctl   = 12'd0;
    req_a     = 32'd0;
    req_b     = 32'd0;
    #12;
    check("reset.req_ready", req_ready, 4'd0);
    check("reset.rsp_valid", rsp_valid, 4'd0);
    check("reset.rsp_data", rsp_data, 9'd0);
    check("reset.rsp_err", rsp_err, 1'b0);
    check("reset.alu", {alu_ctl, alu_a, alu_b}, 19'd0);
    check("reset.busy", busy, 1'b0);
    do_reset();

    // Directed single-requester vectors.
    last_ctl = 3'd0; last_a = 8'd0; last_b = 8'd0;
    for (int i = 0; i < 10; i++) begin
      set_req(vecs[i].req, vecs[i].ctl, vecs[i].a, vecs[i].b);
      serve(vecs[i].req, vecs[i].exp_data, vecs[i].exp_err, vecs[i].stall, $sformatf("vec%0d", i));
      if (!vecs[i].exp_err) begin
        last_ctl = vecs[i].ctl; last_a = vecs[i].a; last_b = vecs[i].b;
      end
      check($sformatf("vec%0d.alu_in", i), {alu_ctl, alu_a, alu_b}, {last_ctl, last_a, last_b});
    end

    // All requesters pending: grants rotate 0,1,2,3,0,1 every 4 cycles.
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 3'b000, 8'(i), 8'(10 * i));
    rsp_ready = 4'hF;
    for (int cyc = 0; cyc < 24; cyc++) begin
      #1;
      if (req_ready != 4'd0) begin
        check("rr.onehot", $countones(req_ready), 1);
        for (int j = 0; j < 4; j++) if (req_ready[j]) g_list.push_back(j);
        c_list.push_back(cyc);
      end
      @(negedge clk);
    end
    req_valid = 4'd0;
    rsp_ready = 4'd0;
    check("rr.count", g_list.size(), 6);
    for (int k = 0; k < g_list.size() && k < 6; k++) begin
      check($sformatf("rr.grant%0d", k), g_list[k], k % 4);
      check($sformatf("rr.cycle%0d", k), c_list[k], 4 * k);
    end

    // Reset during CAPT drops the op; requester 0 wins first afterwards.
    set_req(1, 3'b000, 8'd1, 8'd2);
    #1;
    check("rst.first_ready", req_ready, 4'b0010);
    @(posedge clk);
    @(negedge clk);
    req_valid[1] = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    set_req(0, 3'b001, 8'd9, 8'd4);
    set_req(2, 3'b010, 8'd3, 8'd3);
    #1;
    check("rst.req_ready", req_ready, 4'd0);
    check("rst.rsp_valid", rsp_valid, 4'd0);
    check("rst.rsp_data", {rsp_err, rsp_data}, 10'd0);
    check("rst.alu", {alu_ctl, alu_a, alu_b}, 19'd0);
    check("rst.busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    serve(0, 9'h005, 1'b0, 0, "rst.after0");
    serve(2, 9'h009, 1'b0, 0, "rst.after2");

    // Pointer at 1 with requesters 1 and 3 pending: 3 first, then 1.
    set_req(1, 3'b000, 8'd1, 8'd1);
    serve(1, 9'h002, 1'b0, 0, "p1");
    set_req(1, 3'b100, 8'd7, 8'd8);
    set_req(3, 3'b100, 8'd7, 8'd8);
    serve(3, 9'h00F, 1'b0, 0, "p1.g3");
    serve(1, 9'h00F, 1'b0, 0, "p1.g1");

    // Randomized traffic against a cycle-counting reference.
    do_reset();
    acc = 4'd0; m_phase = 0; m_wait = 0; m_ptr = 3; m_owner = 0; m_res = 10'd0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (acc[i]) req_valid[i] = 1'b0;
        else if (req_valid[i] && $urandom_range(0, 31) == 0) req_valid[i] = 1'b0;
        if (!req_valid[i] && $urandom_range(0, 2) == 0)
          set_req(i, 3'($urandom_range(0, 7)), 8'($urandom),
                  ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom));
      end
      acc = 4'd0;
      rsp_ready = 4'($urandom_range(0, 15));
      #1;
      if (m_phase == 0) begin
        int g;
        g = -1;
        for (int k = 1; k <= 4; k++)
          if (g < 0 && req_valid[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
        check("rnd.ready", req_ready, (g < 0) ? 4'd0 : oh(g));
        check("rnd.rsp_idle", rsp_valid, 4'd0);
        check("rnd.busy_idle", busy, 1'b0);
        if (g >= 0) begin
          m_ptr = g; m_owner = g; acc[g] = 1'b1;
          m_res = ref_op(req_ctl[3*g +: 3], req_a[8*g +: 8], req_b[8*g +: 8]);
          m_phase = 1;
          m_wait = m_res[9] ? 0 : 2;
        end
      end else if (m_wait > 0) begin
        check("rnd.ready_busy", req_ready, 4'd0);
        check("rnd.rsp_early", rsp_valid, 4'd0);
        check("rnd.busy", busy, 1'b1);
        m_wait--;
      end else begin
        check("rnd.ready_resp", req_ready, 4'd0);
        check("rnd.rsp_valid", rsp_valid, oh(m_owner));
        check("rnd.rsp_data", {rsp_err, rsp_data}, m_res);
        if (rsp_ready[m_owner]) m_phase = 0;
      end
    end
    req_valid = 4'd0;
    rsp_ready = 4'hF;
    repeat (6) @(negedge clk);
    check("drain.busy", busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
